// File: rtl/serializer_tx.sv
// serializer_tx: shifts a parallel word out LSB-first as data/strobe pairs, gated per word by the remote ready line.
module serializer_tx #(
    parameter int DATA_WIDTH    = 8,
    parameter int SETUP_CYCLES  = 10,
    parameter int STROBE_CYCLES = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] word_in,
    input  logic                  load_in,
    output logic                  ready_out,
    input  logic                  status_in,
    output logic                  data_out,
    output logic                  write_out,
    output logic                  done_out
);
    localparam int MAX_CYCLES = SETUP_CYCLES > STROBE_CYCLES ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CW = MAX_CYCLES > 1 ? $clog2(MAX_CYCLES) : 1;
    localparam int IW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, WAIT_READY, SETUP, STROBE, DONE} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] shift_q, shift_nx;
    logic [IW-1:0]         bit_idx, bit_idx_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  data_nx, write_nx, done_nx;

    assign ready_out = (state == IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_q   <= '0;
            bit_idx   <= '0;
            cnt       <= '0;
            data_out  <= 1'b0;
            write_out <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            state     <= state_nx;
            shift_q   <= shift_nx;
            bit_idx   <= bit_idx_nx;
            cnt       <= cnt_nx;
            data_out  <= data_nx;
            write_out <= write_nx;
            done_out  <= done_nx;
        end
    end

    // Outputs are computed one edge ahead so data changes only together with the strobe falling edge.
    always_comb begin
        state_nx   = state;
        shift_nx   = shift_q;
        bit_idx_nx = bit_idx;
        cnt_nx     = cnt;
        data_nx    = data_out;
        write_nx   = write_out;
        done_nx    = 1'b0;
        case (state)
            IDLE: begin
                data_nx  = 1'b0;
                write_nx = 1'b0;
                if (load_in) begin
                    shift_nx   = word_in;
                    bit_idx_nx = '0;
                    state_nx   = WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (status_in) begin
                    state_nx = SETUP;
                    cnt_nx   = CW'(SETUP_CYCLES - 1);
                    data_nx  = shift_q[0];
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nx = STROBE;
                    cnt_nx   = CW'(STROBE_CYCLES - 1);
                    write_nx = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    write_nx = 1'b0;
                    if (bit_idx == IW'(DATA_WIDTH - 1)) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        data_nx  = 1'b0;
                    end else begin
                        state_nx   = SETUP;
                        shift_nx   = shift_q >> 1;
                        bit_idx_nx = bit_idx + 1'b1;
                        cnt_nx     = CW'(SETUP_CYCLES - 1);
                        data_nx    = shift_q[1];
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                data_nx  = 1'b0;
                write_nx = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
